// File: rtl/fifo_axis_packet.sv
// fifo_axis_packet: single-clock AXI4-Stream FIFO with first-word-fall-through
// output, optional store-and-forward packet mode, per-beat sideband storage,
// occupancy/packet counters and almost-full/almost-empty flags.
//
// Storage is read asynchronously at the read pointer so the head entry is
// presented in the cycle after it is written. Handshake outputs are derived
// from registered state only. This means s_axis_tready never depends on
// m_axis_tready, and m_axis_tvalid never depends on the inputs of the same cycle.
module fifo_axis_packet #(
    parameter int DWIDTH      = 8,
    parameter int AWIDTH      = 6,
    parameter int USE_TID     = 0,
    parameter int USE_TDEST   = 0,
    parameter int USE_TUSER   = 0,
    parameter int TID_WIDTH   = 8,
    parameter int TDEST_WIDTH = 8,
    parameter int TUSER_WIDTH = 8,
    parameter int PACKET_MODE = 0,
    parameter int AF_MARGIN   = 4,
    parameter int AE_MARGIN   = 4
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    // write side
    input  logic [DWIDTH-1:0]      s_axis_tdata,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic                   s_axis_tlast,
    input  logic [TID_WIDTH-1:0]   s_axis_tid,
    input  logic [TDEST_WIDTH-1:0] s_axis_tdest,
    input  logic [TUSER_WIDTH-1:0] s_axis_tuser,
    // read side
    output logic [DWIDTH-1:0]      m_axis_tdata,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   m_axis_tlast,
    output logic [TID_WIDTH-1:0]   m_axis_tid,
    output logic [TDEST_WIDTH-1:0] m_axis_tdest,
    output logic [TUSER_WIDTH-1:0] m_axis_tuser,
    // status
    output logic [AWIDTH:0]        wr_data_count,
    output logic [AWIDTH:0]        rd_data_count,
    output logic [AWIDTH:0]        packet_count,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic                   oversize_err
);

    localparam int DEPTH = 2 ** AWIDTH;
    localparam logic [AWIDTH:0] AF_LEVEL = (AWIDTH + 1)'(DEPTH - AF_MARGIN);
    localparam logic [AWIDTH:0] AE_LEVEL = (AWIDTH + 1)'(AE_MARGIN);
    localparam logic [AWIDTH:0] PTR_ONE  = (AWIDTH + 1)'(1);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AWIDTH:0] wr_ptr_q, wr_ptr_d;
    logic [AWIDTH:0] rd_ptr_q, rd_ptr_d;
    // End of the readable region; equals wr_ptr whenever packet mode is off.
    logic [AWIDTH:0] commit_ptr_q, commit_ptr_d;
    logic [AWIDTH:0] pkt_cnt_q, pkt_cnt_d;
    // Set while an oversize packet is being passed through cut-through.
    logic            cut_q, cut_d;
    logic            ovf_q, ovf_d;
    // Holds tready low during reset and releases it on the first clock edge.
    logic            ready_q;

    logic [AWIDTH-1:0] wr_idx;
    logic [AWIDTH-1:0] rd_idx;
    logic              full;
    logic              wr_fire;
    logic              rd_fire;
    logic              wr_last;
    logic              rd_last;

    // Payload storage (no reset: contents are don't-care until written)
    logic [DWIDTH-1:0] data_mem [DEPTH];
    logic              last_mem [DEPTH];

    assign wr_idx = wr_ptr_q[AWIDTH-1:0];
    assign rd_idx = rd_ptr_q[AWIDTH-1:0];

    assign full = (wr_ptr_q[AWIDTH] != rd_ptr_q[AWIDTH]) &&
                  (wr_ptr_q[AWIDTH-1:0] == rd_ptr_q[AWIDTH-1:0]);

    assign s_axis_tready = ready_q & ~full;
    assign wr_fire       = s_axis_tvalid & s_axis_tready;

    assign wr_data_count = wr_ptr_q - rd_ptr_q;
    assign rd_data_count = (PACKET_MODE != 0) ? (commit_ptr_q - rd_ptr_q) : wr_data_count;

    assign m_axis_tvalid = (rd_data_count != '0);
    assign rd_fire       = m_axis_tvalid & m_axis_tready;

    assign m_axis_tdata  = data_mem[rd_idx];
    assign m_axis_tlast  = last_mem[rd_idx];

    assign wr_last = wr_fire & s_axis_tlast;
    assign rd_last = rd_fire & m_axis_tlast;

    assign packet_count  = pkt_cnt_q;
    assign almost_full   = (wr_data_count >= AF_LEVEL);
    assign almost_empty  = (rd_data_count <= AE_LEVEL);
    assign oversize_err  = ovf_q;

    // Payload write port
    always_ff @(posedge aclk) begin
        if (wr_fire) begin
            data_mem[wr_idx] <= s_axis_tdata;
            last_mem[wr_idx] <= s_axis_tlast;
        end
    end

    // Sideband storage exists only for the enabled fields; disabled outputs read 0.
    generate
        if (USE_TID != 0) begin : g_tid
            logic [TID_WIDTH-1:0] tid_mem [DEPTH];
            // TID write port
            always_ff @(posedge aclk) begin
                if (wr_fire) begin
                    tid_mem[wr_idx] <= s_axis_tid;
                end
            end
            assign m_axis_tid = tid_mem[rd_idx];
        end else begin : g_no_tid
            logic unused_tid;
            assign unused_tid = ^s_axis_tid;
            assign m_axis_tid = '0;
        end

        if (USE_TDEST != 0) begin : g_tdest
            logic [TDEST_WIDTH-1:0] tdest_mem [DEPTH];
            // TDEST write port
            always_ff @(posedge aclk) begin
                if (wr_fire) begin
                    tdest_mem[wr_idx] <= s_axis_tdest;
                end
            end
            assign m_axis_tdest = tdest_mem[rd_idx];
        end else begin : g_no_tdest
            logic unused_tdest;
            assign unused_tdest = ^s_axis_tdest;
            assign m_axis_tdest = '0;
        end

        if (USE_TUSER != 0) begin : g_tuser
            logic [TUSER_WIDTH-1:0] tuser_mem [DEPTH];
            // TUSER write port
            always_ff @(posedge aclk) begin
                if (wr_fire) begin
                    tuser_mem[wr_idx] <= s_axis_tuser;
                end
            end
            assign m_axis_tuser = tuser_mem[rd_idx];
        end else begin : g_no_tuser
            logic unused_tuser;
            assign unused_tuser = ^s_axis_tuser;
            assign m_axis_tuser = '0;
        end
    endgenerate

    // Next-state logic for pointers, commit point, packet counter and error flag
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        commit_ptr_d = commit_ptr_q;
        pkt_cnt_d    = pkt_cnt_q;
        cut_d        = cut_q;
        ovf_d        = ovf_q;

        if (wr_fire) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (rd_fire) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        if (PACKET_MODE != 0) begin
            if (wr_fire && (s_axis_tlast || cut_q)) begin
                // A closing beat, or any beat of an oversize packet, becomes readable.
                commit_ptr_d = wr_ptr_q + PTR_ONE;
            end else if (full && (pkt_cnt_q == '0)) begin
                // Full with no complete packet: the packet can never fit, so
                // release what is stored and pass the rest through.
                commit_ptr_d = wr_ptr_q;
                cut_d        = 1'b1;
                ovf_d        = 1'b1;
            end
            if (wr_last) begin
                cut_d = 1'b0;
            end
        end

        case ({wr_last, rd_last})
            2'b10:   pkt_cnt_d = pkt_cnt_q + PTR_ONE;
            2'b01:   pkt_cnt_d = pkt_cnt_q - PTR_ONE;
            default: pkt_cnt_d = pkt_cnt_q;
        endcase
    end

    // State registers, cleared asynchronously by aresetn
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            commit_ptr_q <= '0;
            pkt_cnt_q    <= '0;
            cut_q        <= 1'b0;
            ovf_q        <= 1'b0;
            ready_q      <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            pkt_cnt_q    <= pkt_cnt_d;
            cut_q        <= cut_d;
            ovf_q        <= ovf_d;
            ready_q      <= 1'b1;
        end
    end

endmodule

// File: doc/fifo_axis_packet.md
FIFO_AXIS_PACKET -- requirements
Module: fifo_axis_packet

Interface
REQ-001 SHALL have parameter DWIDTH, default 8: tdata width.
REQ-002 SHALL have parameter AWIDTH, default 6: address width; DEPTH = 2**AWIDTH words.
REQ-003 SHALL have parameters USE_TID/USE_TDEST/USE_TUSER, default 0, with widths TID_WIDTH/TDEST_WIDTH/TUSER_WIDTH, default 8: sideband stored only when enabled, outputs tied 0 otherwise.
REQ-004 SHALL have parameter PACKET_MODE, default 0: 1 = store-and-forward on tlast.
REQ-005 SHALL have parameters AF_MARGIN, default 4, and AE_MARGIN, default 4: almost-flag thresholds in words.
REQ-006 SHALL have ports, with clock and reset first:
- aclk  in  1  single clock.
- aresetn  in  1  asynchronous, active-low reset.
- s_axis_tdata/tvalid/tready/tlast/tid/tdest/tuser  slave  DWIDTH/1/1/1/sideband widths  write side.
- m_axis_tdata/tvalid/tready/tlast/tid/tdest/tuser  master  same widths  read side.
- wr_data_count  out  AWIDTH+1  words stored.
- rd_data_count  out  AWIDTH+1  words readable.
- packet_count  out  AWIDTH+1  complete packets stored.
- almost_full  out  1.
- almost_empty  out  1.
- oversize_err  out  1  sticky.

Function
REQ-007 SHALL accept a write when s_axis_tvalid & s_axis_tready; s_axis_tready = (wr_data_count < DEPTH), registered state only, with no combinational path from m_axis_tready.
REQ-008 SHALL complete a read when m_axis_tvalid & m_axis_tready; m_axis_t* SHALL present the head entry first-word-fall-through and stay stable while tvalid=1 and tready=0.
REQ-009 SHALL, with PACKET_MODE=0, raise m_axis_tvalid the cycle after the first write into an empty FIFO (1-cycle latency); readable = stored.
REQ-010 SHALL, with PACKET_MODE=1, keep a commit pointer advanced to the write pointer+1 on each accepted beat with tlast=1; readable = rd_ptr..commit_ptr; m_axis_tvalid=0 until at least one full packet is stored.
REQ-011 SHALL increment packet_count on an accepted tlast write and decrement it on an accepted tlast read; simultaneous events leave it unchanged. With PACKET_MODE=0 it counts tlast beats stored.
REQ-012 SHALL use AWIDTH+1-bit pointers with natural wrap-around; full = MSBs differ and LSBs equal; empty = pointers equal.
REQ-013 SHALL leave wr_data_count unchanged on a simultaneous write and read; no write is accepted at full even if a read occurs in the same cycle.
REQ-014 SHALL drive almost_full = (wr_data_count >= DEPTH-AF_MARGIN) and almost_empty = (rd_data_count <= AE_MARGIN), both registered-consistent with the counts in the same cycle.
REQ-015 SHALL, when PACKET_MODE=1, the FIFO is full and packet_count=0 (oversize packet), set oversize_err and move commit_ptr to wr_ptr so stored beats drain cut-through until the next tlast; normal store-and-forward then resumes.
REQ-016 SHALL clear oversize_err only by reset.
REQ-017 SHALL hold m_axis_tvalid=0 when readable=0, including when a write and a read of the last readable word coincide.

Reset
REQ-018 SHALL, while aresetn=0 (asserted asynchronously), clear all pointers, counts, packet_count and oversize_err to 0, and drive s_axis_tready=0, m_axis_tvalid=0, almost_empty=1 and almost_full=0.
REQ-019 SHALL drive s_axis_tready=1 on the first aclk edge after aresetn deasserts; reset mid-packet discards all contents and partial packets.
REQ-020 SHALL NOT reset the memory contents.

Verification
REQ-021 SHALL cover PACKET_MODE=0, DEPTH=64: write 64 words 0..63 with tready low -> s_axis_tready=0 after word 64, wr_data_count=64, almost_full from count 60; then drain -> 0..63 in order.
REQ-022 SHALL cover PACKET_MODE=1: 5-beat packet, tlast on beat 5 -> m_axis_tvalid=0 through beat 4, =1 the cycle after beat 5, packet_count=1, rd_data_count=5.
REQ-023 SHALL cover a continuous write and read at full rate for 1000 beats with random m_axis_tready -> no loss or duplication, counts stay within 0..64, pointer wrap verified.
REQ-024 SHALL cover PACKET_MODE=1 with a 70-beat packet into DEPTH=64 -> oversize_err=1 at full, data drains, all 70 beats received in order, tlast on beat 70.
REQ-025 SHALL cover reset asserted mid-packet with 10 words stored -> counts=0 and tvalid=0 immediately; s_axis_tready=1 one edge after release.
REQ-026 SHALL cover USE_TID=USE_TUSER=1: sideband values stay aligned per beat; USE_TDEST=0 -> m_axis_tdest=0.
